// File: rtl/dc_ipu_scale_stepper.sv
// Nearest-neighbour source-index stepper: emits floor(k*src/dst) for k=0..dst-1 via remainder accumulation.
// Latency: first index is valid the cycle after a configuration is accepted, then one index per cycle.
// Backpressure: out_ready low freezes all state and outputs; flush aborts the line and wins over any handshake.
module dc_ipu_scale_stepper #(
    parameter int COORD_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COORD_WIDTH-1:0] cfg_q,
    input  logic [COORD_WIDTH-1:0] cfg_r,
    input  logic [COORD_WIDTH-1:0] cfg_dst_size,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_WIDTH-1:0] out_idx,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   cfg_err
);

    localparam int W = COORD_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   q, q_nxt;
    logic [W-1:0]   r, r_nxt;
    logic [W-1:0]   dst, dst_nxt;
    logic [W-1:0]   idx, idx_nxt;
    logic [W:0]     err, err_nxt;
    logic [W-1:0]   k, k_nxt;
    logic           err_pulse_nxt;

    // Remainder sum is one bit wider than dst so err + r < 2*dst never wraps.
    logic [W:0]     sum;
    logic [W-1:0]   dst_m1;
    logic           at_last;
    logic           cfg_bad;

    assign sum     = err + {1'b0, r};
    assign dst_m1  = dst - W'(1);
    assign at_last = (k == dst_m1);
    assign cfg_bad = (cfg_dst_size == '0) || (cfg_r >= cfg_dst_size);

    // Outputs are decoded from registered state only; cfg_ready additionally masks on flush.
    assign cfg_ready = (state == IDLE) && !flush;
    assign out_valid = (state == RUN);
    assign out_idx   = idx;
    assign out_first = (state == RUN) && (k == '0);
    assign out_last  = (state == RUN) && at_last;

    // Next-state and datapath update: accept/reject in IDLE, step the index on each RUN handshake.
    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        r_nxt         = r;
        dst_nxt       = dst;
        idx_nxt       = idx;
        err_nxt       = err;
        k_nxt         = k;
        err_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid && !flush) begin
                    if (cfg_bad) begin
                        err_pulse_nxt = 1'b1;
                    end else begin
                        q_nxt     = cfg_q;
                        r_nxt     = cfg_r;
                        dst_nxt   = cfg_dst_size;
                        idx_nxt   = '0;
                        err_nxt   = '0;
                        k_nxt     = '0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                    end else begin
                        k_nxt = k + W'(1);
                        if (sum >= {1'b0, dst}) begin
                            err_nxt = sum - {1'b0, dst};
                            idx_nxt = idx + q + W'(1);
                        end else begin
                            err_nxt = sum;
                            idx_nxt = idx + q;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so a partial line never resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q       <= '0;
            r       <= '0;
            dst     <= '0;
            idx     <= '0;
            err     <= '0;
            k       <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            r       <= r_nxt;
            dst     <= dst_nxt;
            idx     <= idx_nxt;
            err     <= err_nxt;
            k       <= k_nxt;
            cfg_err <= err_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_dc_ipu_scale_stepper.sv
// Bench for dc_ipu_scale_stepper: table of line configurations, hand-written flush/reset sequences, random lines.
// Reference index for output k is floor(k*src/dst) computed directly with wide integer arithmetic.
// out_ready is randomised per cycle; held outputs are compared against the previous cycle while stalled.
module tb_dc_ipu_scale_stepper;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_q;
    logic [11:0] cfg_r;
    logic [11:0] cfg_dst_size;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_idx;
    logic        out_first;
    logic        out_last;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int got[$];

    dc_ipu_scale_stepper #(.COORD_WIDTH(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_q        (cfg_q),
        .cfg_r        (cfg_r),
        .cfg_dst_size (cfg_dst_size),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_first    (out_first),
        .out_last     (out_last),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int d;
        bit rej;
        int pct;
        int f0;
        int f1;
        int f2;
        int last;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint ref_idx(input longint k, input longint src, input longint d);
        return (k * src) / d;
    endfunction

    // Offer one configuration for a single cycle; returns at the negedge after the accepting edge.
    task automatic start_cfg(input int q, input int r, input int d);
        @(negedge clk);
        cfg_q        = 12'(q);
        cfg_r        = 12'(r);
        cfg_dst_size = 12'(d);
        cfg_valid    = 1'b1;
        #1 chk("cfg_ready_at_offer", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Run a complete line with out_ready asserted pct% of cycles, checking every output.
    task automatic run_line(input int q, input int r, input int d, input int pct, output int n);
        longint      src;
        int          cyc;
        bit          stalled;
        logic [11:0] p_idx;
        logic        p_first;
        logic        p_last;
        src     = longint'(q) * d + r;
        n       = 0;
        cyc     = 0;
        stalled = 0;
        p_idx   = '0;
        p_first = 0;
        p_last  = 0;
        got.delete();
        start_cfg(q, r, d);
        while (n < d && cyc < 4 * d + 200) begin
            chk("out_valid_in_run", out_valid, 1);
            if (!out_valid) break;
            if (stalled) begin
                chk("stall_idx_stable", out_idx, p_idx);
                chk("stall_first_stable", out_first, p_first);
                chk("stall_last_stable", out_last, p_last);
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_ready) begin
                chk("idx", out_idx, ref_idx(n, src, d));
                chk("first", out_first, (n == 0));
                chk("last", out_last, (n == d - 1));
                got.push_back(int'(out_idx));
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                p_idx   = out_idx;
                p_first = out_first;
                p_last  = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("line_completed_in_budget", n, d);
        chk("idle_after_line_valid", out_valid, 0);
        chk("idle_after_line_cfg_ready", cfg_ready, 1);
    endtask

    task automatic reject_cfg(input int q, input int r, input int d);
        @(negedge clk);
        cfg_q        = 12'(q);
        cfg_r        = 12'(r);
        cfg_dst_size = 12'(d);
        cfg_valid    = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("reject_err_pulse", cfg_err, 1);
        chk("reject_no_valid", out_valid, 0);
        @(negedge clk);
        chk("reject_err_one_cycle", cfg_err, 0);
        chk("reject_still_no_valid", out_valid, 0);
        chk("reject_cfg_ready", cfg_ready, 1);
    endtask

    // Step n handshakes of an already-started line with out_ready high.
    task automatic step_n(input longint src, input int d, input int nsteps);
        for (int i = 0; i < nsteps; i++) begin
            out_ready = 1'b1;
            chk("partial_idx", out_idx, ref_idx(i, src, d));
            @(negedge clk);
        end
    endtask

    vec_t tbl[7];

    initial begin
        int n;
        int d;
        int src;

        tbl[0] = '{1, 640, 1280, 0, 100, 0, 1, 3, 1918};
        tbl[1] = '{0, 720, 1280, 0, 100, 0, 0, 1, 719};
        tbl[2] = '{2, 1, 3, 0, 50, 0, 2, 4, 4};
        tbl[3] = '{0, 0, 0, 1, 100, 0, 0, 0, 0};
        tbl[4] = '{0, 5, 5, 1, 100, 0, 0, 0, 0};
        tbl[5] = '{7, 0, 1, 0, 100, 0, 0, 0, 0};
        tbl[6] = '{1, 9, 4, 1, 100, 0, 0, 0, 0};

        rst_n        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_q        = '0;
        cfg_r        = '0;
        cfg_dst_size = '0;
        flush        = 1'b0;
        out_ready    = 1'b0;

        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cfg_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of line configurations.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rej) begin
                reject_cfg(tbl[i].q, tbl[i].r, tbl[i].d);
            end else begin
                run_line(tbl[i].q, tbl[i].r, tbl[i].d, tbl[i].pct, n);
                chk("tbl_count", n, tbl[i].d);
                if (got.size() > 0) begin
                    chk("tbl_idx0", got[0], tbl[i].f0);
                    chk("tbl_last_idx", got[got.size() - 1], tbl[i].last);
                end
                if (got.size() > 1) chk("tbl_idx1", got[1], tbl[i].f1);
                if (got.size() > 2) chk("tbl_idx2", got[2], tbl[i].f2);
            end
        end

        // Flush at k=100 of the 1920->1280 line, with a handshake and a cfg offer colliding.
        start_cfg(1, 640, 1280);
        step_n(1920, 1280, 100);
        chk("flush_k100_idx", out_idx, 150);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("flush_drops_valid", out_valid, 0);
        #1 chk("flush_idle_cfg_ready_low", cfg_ready, 0);
        cfg_q        = 12'd2;
        cfg_r        = 12'd1;
        cfg_dst_size = 12'd3;
        cfg_valid    = 1'b1;
        @(negedge clk);
        chk("flush_blocks_cfg_valid", out_valid, 0);
        chk("flush_blocks_cfg_err", cfg_err, 0);
        cfg_valid = 1'b0;
        flush     = 1'b0;
        #1 chk("flush_release_cfg_ready", cfg_ready, 1);
        run_line(2, 1, 3, 100, n);

        // Asynchronous reset in the middle of a line.
        start_cfg(1, 640, 1280);
        step_n(1920, 1280, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_out_first", out_first, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_cfg_err", cfg_err, 0);
        @(negedge clk);
        chk("midrst_no_resume", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_no_resume", out_valid, 0);
        run_line(0, 3, 4, 60, n);

        // Random golden lines.
        for (int i = 0; i < 8; i++) begin
            d   = $urandom_range(4095, 1);
            src = $urandom_range(4095, 1);
            run_line(src / d, src % d, d, 75, n);
            chk("rand_count", n, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_ipu_scale_stepper.md
# dc_ipu_scale_stepper

Nearest-neighbour coordinate stepper for the IPU scaler, placed directly downstream of the IPU divider. It consumes the divider's quotient and remainder for src_size / dst_size. For every output pixel k = 0 … dst_size−1 it emits the source index floor(k·src_size/dst_size), one per cycle. It uses Bresenham-style remainder accumulation, so no multiplier or per-pixel divide is needed.

## Interface

- COORD_WIDTH, 12: width of sizes, quotient, remainder and indices (sizes up to 2^COORD_WIDTH−1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  stepper can accept a configuration.
- cfg_q  in  COORD_WIDTH  integer step (divider quotient).
- cfg_r  in  COORD_WIDTH  fractional step numerator (divider remainder).
- cfg_dst_size  in  COORD_WIDTH  number of outputs to generate; also the fractional denominator.
- flush  in  1  synchronous abort of the current line.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx.
- out_idx  out  COORD_WIDTH  source index for the current output pixel.
- out_first  out  1  current output is k = 0.
- out_last  out  1  current output is k = dst_size−1.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.

## Operation

- **States.** The block has two states: IDLE and RUN.
- **Registers.**
  - Stored configuration: q, r, dst.
  - idx (COORD_WIDTH).
  - err (COORD_WIDTH+1, so err+r < 2·dst cannot overflow).
  - k (COORD_WIDTH).
- **IDLE.**
  - cfg_ready=1, out_valid=0.
  - Configuration is accepted on cfg_valid && cfg_ready. The block captures q, r and dst, and sets idx=0, err=0, k=0.
  - After an accepted configuration the next state is RUN.
  - The configuration is rejected (state stays IDLE, cfg_err pulses high for one cycle, nothing emitted) when either:
    - cfg_dst_size = 0, or
    - cfg_r ≥ cfg_dst_size.
- **RUN.**
  - cfg_ready=0, out_valid=1.
  - Output fields: out_idx=idx, out_first=(k==0), out_last=(k==dst−1).
- **Output handshake** (out_valid && out_ready, with no flush):
  - If k==dst−1, the next state is IDLE.
  - Otherwise:
    - k+=1.
    - s = err + r.
    - If s ≥ dst: err = s − dst and idx += q + 1.
    - Else: err = s and idx += q.
- **Backpressure.** While out_ready=0, all registers hold and out_idx/out_first/out_last stay stable.
- **flush.** flush=1 forces IDLE next cycle from any state. It has priority over a simultaneous handshake or cfg acceptance. A flushed transfer is not counted as consumed. In IDLE with flush=1, cfg_ready=0.
- **Arithmetic.**
  - All additions are unsigned.
  - idx never exceeds src_size−1 for a valid configuration, where src_size = q·dst + r.
  - No wrap handling is required beyond COORD_WIDTH truncation.

## Timing

- **Reset values.** With rst_n low, the state is IDLE and the outputs are:
  - cfg_ready=1;
  - out_valid=0;
  - out_idx=0, out_first=0, out_last=0;
  - cfg_err=0.
  - Internal registers are 0.
- **Reset mid-run.** Assertion is immediate (asynchronous); deassertion is synchronous to clk. Reset mid-RUN drops out_valid immediately, and no partial line resumes.
- **Latency.** A configuration accepted at edge N gives out_valid=1 with k=0 after edge N. That first output is visible in cycle N+1.
- **Throughput.** One index per cycle with out_ready held high. A line of D outputs occupies D cycles in RUN.
- **Line turnaround.** After the last handshake the block spends one IDLE cycle (cfg_ready=1) before a new configuration can be accepted. Minimum line period is D+1 cycles.
- **Registered outputs.** All outputs come from registers; there is no combinational path from cfg_* or out_ready to out_*. cfg_ready depends combinationally on flush only.
- **cfg_err.** Asserted in the cycle after the rejected cfg_valid, for exactly one cycle.

## Test plan

- **Downscale 1920→1280.** Configure q=1, r=640, dst=1280 with out_ready=1.
  - The first indices must be 0,1,3,4,6,7.
  - The last index must be 1918 with out_last=1.
  - Exactly 1280 transfers; out_first only on the first.
  - cfg_ready returns one cycle after the last transfer.
- **Upscale 720→1280.** Configure q=0, r=720, dst=1280.
  - Indices must start 0,0,1,1,2 (each equal to floor(k·720/1280)).
  - The final index must be 719.
  - The index is monotonic non-decreasing with steps ≤ 1.
- **Backpressure.** Run q=2, r=1, dst=3 with out_ready toggled randomly.
  - Required sequence: 0,2,4, unchanged by stalls.
  - Outputs must be stable while out_valid && !out_ready.
- **Rejects and degenerate sizes.**
  - cfg_dst_size=0: must be rejected with a one-cycle cfg_err pulse and no out_valid.
  - cfg_r=5 with cfg_dst_size=5: must be rejected the same way.
  - dst=1, q=7, r=0: must emit a single index 0 with out_first=out_last=1.
- **Flush and reset.**
  - Assert flush at k=100 of the 1920→1280 line. out_valid must drop next cycle, and a new configuration must be accepted after flush deasserts.
  - Repeat with rst_n pulsed low mid-line. Outputs must reach reset values without a clock edge.
- **Randomised golden check.** For random src, dst ∈ [1, 4095], feed q=src/dst and r=src%dst. Every out_idx must equal floor(k·src/dst), with exactly dst outputs.
